// File: rtl/reg_dump_reader_pkg.sv
// Shared sizes and FSM encoding for the register dump reader.
// CSUM is only entered when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_reader_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        CSUM  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_reader_outreg.sv
// Single-entry valid/ready holding register for dump beats.
// A beat is replaced in the same cycle it is consumed.
module reg_dump_outreg
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int IDX_W  = REG_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic              load_last,
    input  logic              load_csum,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [IDX_W-1:0]  idx,
    output logic              last,
    output logic              csum,
    output logic              free
);

    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            idx   <= '0;
            last  <= 1'b0;
            csum  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            idx   <= load_idx;
            last  <= load_last;
            csum  <= load_csum;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file read port over [first_reg, last_reg] and streams beats.
// Optional trailing XOR checksum beat: define REG_DUMP_CHECKSUM_EN.
module reg_dump_reader #(
    parameter int DATA_W   = reg_dump_reader_pkg::REG_DATA_W,
    parameter int IDX_W    = reg_dump_reader_pkg::REG_IDX_W,
    parameter int NUM_REGS = reg_dump_reader_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_reg,
    input  logic [IDX_W-1:0]  last_reg,
    output logic [IDX_W-1:0]  readnum,
    input  logic [DATA_W-1:0] rf_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [IDX_W-1:0]  dump_idx,
    output logic              dump_last,
    output logic              dump_csum,
    output logic              busy,
    output logic              done,
    output logic              error
);
    import reg_dump_reader_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  end_idx;
    logic              free;
    logic              load;
    logic              at_end;
    logic              start_bad;
    logic [DATA_W-1:0] load_data;
    logic [IDX_W-1:0]  load_idx;
    logic              load_last;
    logic              load_csum;

    assign at_end    = (ptr == end_idx);
    // Range guard only bites when NUM_REGS < 2**IDX_W.
    assign start_bad = (first_reg > last_reg) ||
                       (int'(last_reg) >= NUM_REGS);
    assign readnum   = (state == IDLE) ? '0 : ptr;

    assign load      = free &&
                       (state == READ || (CSUM_ON && state == CSUM));
    assign load_idx  = (state == CSUM) ? end_idx : ptr;
    assign load_last = (state == CSUM) || (at_end && !CSUM_ON);
    assign load_csum = CSUM_ON && (state == CSUM);

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (state == IDLE && start && !start_bad)
            acc <= '0;
        else if (state == READ && load)
            acc <= acc ^ rf_data;
    end

    assign load_data = (state == CSUM) ? acc : rf_data;
`else
    assign load_data = rf_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            end_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && start_bad) begin
                        error <= 1'b1;
                    end else if (start) begin
                        ptr     <= first_reg;
                        end_idx <= last_reg;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (free && at_end)
                        state <= CSUM_ON ? CSUM : DRAIN;
                    else if (free)
                        ptr <= ptr + 1'b1;
                end
                CSUM: begin
                    if (free)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (dump_valid && dump_ready) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    reg_dump_outreg #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_outreg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_idx  (load_idx),
        .load_last (load_last),
        .load_csum (load_csum),
        .ready     (dump_ready),
        .valid     (dump_valid),
        .data      (dump_data),
        .idx       (dump_idx),
        .last      (dump_last),
        .csum      (dump_csum),
        .free      (free)
    );

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Sequential reader for the 32x32 register file read port. On a start pulse it walks readnum from first_reg to last_reg and captures each value returned by the register file.
- It streams the captured values out as index-tagged beats over a valid/ready interface.
- It sits between the register file and the debug/trace path, so the CPU register state can be dumped without core involvement.

Parameters:
- DATA_W, 32, register width
- IDX_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**IDX_W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; ignored while busy
- first_reg  in  IDX_W  first index to read; sampled on accepted start
- last_reg  in  IDX_W  last index to read, inclusive; sampled on accepted start
- readnum  out  IDX_W  drives the register file readnum
- rf_data  in  DATA_W  register file data_out; combinational from readnum, valid in the same cycle
- dump_valid  out  1  beat available
- dump_ready  in  1  downstream accepts the beat
- dump_data  out  DATA_W  register value, or checksum (see Optional Feature)
- dump_idx  out  IDX_W  index of the register in dump_data
- dump_last  out  1  final beat of the dump
- dump_csum  out  1  beat is a checksum beat; tied 0 when the feature is compiled out
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the final beat is accepted
- error  out  1  one-cycle pulse when start is rejected because first_reg > last_reg

Behaviour:
- Reset values: readnum=0, dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, dump_csum=0, busy=0, done=0, error=0. The FSM goes to IDLE.
- Reset mid-dump aborts the dump immediately. No further beats are produced and no done pulse is issued.
- Accepted start: start=1 while in IDLE.
  - If first_reg > last_reg: pulse error on the next cycle, stay in IDLE, produce no beats.
  - Otherwise: latch ptr=first_reg and end=last_reg, then go to READ with busy=1 from the next cycle.
- FSM states: IDLE, READ, DRAIN.
- IDLE: readnum=0.
- READ: readnum=ptr.
  - The output register is free when dump_valid=0, or when dump_valid&dump_ready are both 1.
  - When free, load dump_data=rf_data, dump_idx=ptr, dump_last=(ptr==end), and set dump_valid=1.
  - If ptr==end, go to DRAIN; otherwise ptr+1.
  - When not free, hold ptr and readnum (stall).
- DRAIN: hold the beat until it is accepted. On acceptance: dump_valid=0, busy=0, done=1 for one cycle, go to IDLE.
- Throughput and latency:
  - With dump_ready held at 1, the dump produces one beat per cycle.
  - Start accepted at edge t gives the first dump_valid after edge t+1.
  - N registers finish with done high in the cycle after the last handshake.
- Beat stability: dump_data, dump_idx and dump_last stay stable while dump_valid=1 and dump_ready=0.
- Coherency: each value reflects register contents in its capture cycle. Concurrent register file writes are not blocked, so no atomic snapshot is guaranteed.
- Boundaries:
  - ptr never wraps, because end is at most NUM_REGS-1 and the comparison happens before increment.
  - first_reg==last_reg produces a single beat with dump_last=1.
  - x0 is read like any other register.
  - start while busy is ignored, with no error pulse.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - A DATA_W XOR accumulator clears on accepted start and folds in each register beat as it is loaded.
  - After the last register beat is loaded, one extra beat follows with dump_data=accumulator, dump_idx=end, dump_csum=1, dump_last=1.
  - The register beats then all carry dump_last=0.
  - An added state CSUM sits between READ and DRAIN.
- Undefined: no accumulator, no extra beat, dump_csum tied 0.

Decomposition:
- Shared package (defines.sv):
  - state enum {IDLE, READ, DRAIN, CSUM}
  - REG_IDX_W=5, REG_DATA_W=32, NUM_REGS=32
- Sub-module: one output register, reg_dump_outreg. It is a valid/ready holding register with load/consume and a free output.
- The FSM and pointer stay in the top module.

Test Plan:
- Registers preloaded x_i=0x1000+i; first=0, last=31, ready=1 -> 32 beats, idx 0..31, data 0x1000..0x101F, dump_last only on idx 31, done one cycle after the last handshake.
- first=5, last=8; ready toggles 1,0,0,1,... -> 4 beats idx 5..8 in order. Data/idx are stable during stalls and readnum holds while stalled.
- first=7, last=7 -> one beat idx 7, dump_last=1, done pulses. Then first=9, last=3 -> error pulse, no dump_valid, busy stays 0.
- Reset asserted for 1 cycle during beat idx 12 of a 0..31 dump -> dump_valid=0, busy=0, and no done pulse. A fresh start of 0..1 then works normally.
- start pulsed again while busy -> ignored: no error, and the beat sequence is unchanged.
- With REG_DUMP_CHECKSUM_EN and x1=0xF0F0F0F0, x2=0x0F0F0F0F; first=1, last=2 -> beats 1 and 2 with dump_last=0, then a checksum beat 0xFFFFFFFF with dump_csum=1, dump_last=1.
